logic_unit_arbiter: RTL

Shares one combinational 8-bit logic unit (AND/XOR/OR/NOT-B, selected by `s2`/`s3`) between two requesters. Each request carries an op code and two operands. A round-robin arbiter grants one request at a time, drives registered operands and select lines to the shared unit, captures its result, and returns it with the requester ID over a valid/ready result channel. The block sits between the ALU's two command sources (e.g. core issue port and debug/test port) and the logic unit instance.

---
 rtl/logic_unit_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one combinational logic unit between two requesters.
// Optional LOGIC_ARB_ZERO_FLAG_EN adds res_zero_o, a registered all-zero flag on the result.
module logic_unit_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid_i,
    output logic [1:0]   req_ready_o,
    input  logic [1:0]   req_op0_i,
    input  logic [1:0]   req_op1_i,
    input  logic [N-1:0] req_a0_i,
    input  logic [N-1:0] req_b0_i,
    input  logic [N-1:0] req_a1_i,
    input  logic [N-1:0] req_b1_i,
    output logic [N-1:0] lu_a_o,
    output logic [N-1:0] lu_b_o,
    output logic         lu_s2_o,
    output logic         lu_s3_o,
    input  logic [N-1:0] lu_rl_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [N-1:0] res_data_o,
    output logic         res_id_o,
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    output logic         res_zero_o,
`endif
    output logic         busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic         r_prio;
    logic [N-1:0] r_lu_a;
    logic [N-1:0] r_lu_b;
    logic [1:0]   r_lu_op;
    logic [N-1:0] r_res_data;
    logic         r_res_id;
    logic [1:0]   w_grant;
    logic [1:0]   w_ready;
    logic         w_accept;
    logic         w_sel;

    // Contention resolved by r_prio; a lone requester wins regardless of it.
    always_comb begin
        w_grant[0] = req_valid_i[0] && (!req_valid_i[1] || !r_prio);
        w_grant[1] = req_valid_i[1] && (!req_valid_i[0] ||  r_prio);
        w_ready    = ((r_state == ST_IDLE) && rst_n) ? w_grant : 2'b00;
        w_accept   = |w_ready;
        w_sel      = w_ready[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_next = ST_EXEC;
            ST_EXEC:                  w_state_next = ST_RESP;
            ST_RESP: if (res_ready_i) w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    // Logic-unit inputs change only on acceptance so the unit sees stable operands in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio   <= 1'b0;
            r_lu_a   <= '0;
            r_lu_b   <= '0;
            r_lu_op  <= 2'b00;
            r_res_id <= 1'b0;
        end else if (w_accept) begin
            r_prio   <= ~w_sel;
            r_lu_a   <= w_sel ? req_a1_i  : req_a0_i;
            r_lu_b   <= w_sel ? req_b1_i  : req_b0_i;
            r_lu_op  <= w_sel ? req_op1_i : req_op0_i;
            r_res_id <= w_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_data <= '0;
        end else if (r_state == ST_EXEC) begin
            r_res_data <= lu_rl_i;
        end
    end

`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic r_res_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_zero <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_res_zero <= (lu_rl_i == '0);
        end
    end

    assign res_zero_o = r_res_zero;
`endif

    assign req_ready_o = w_ready;
    assign lu_a_o      = r_lu_a;
    assign lu_b_o      = r_lu_b;
    assign lu_s2_o     = r_lu_op[1];
    assign lu_s3_o     = r_lu_op[0];
    assign res_valid_o = (r_state == ST_RESP);
    assign res_data_o  = r_res_data;
    assign res_id_o    = r_res_id;
    assign busy_o      = (r_state != ST_IDLE);

endmodule
